// File: rtl/pipelined_rv_core.sv
// rtl/pipelined_rv_core.sv - three-stage (IF/EX/WB) RV32I-subset core with loadable imem
// Forwarding covers the only hazard: EX reading the register that WB is committing.
module pipelined_rv_core #(
  parameter int XLEN       = 16,
  parameter int NREGS      = 32,
  parameter int IMEM_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          hold,
  input  logic                          load_en,
  input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
  input  logic [31:0]                   load_data,
  output logic [XLEN-1:0]               out,
  output logic                          out_valid,
  output logic [$clog2(IMEM_DEPTH)-1:0] pc_out
);
  localparam int RAW     = $clog2(NREGS);
  localparam int IMEM_AW = $clog2(IMEM_DEPTH);
  localparam int SHW     = $clog2(XLEN);

  logic [31:0]        imem [IMEM_DEPTH];
  logic [XLEN-1:0]    regs [NREGS];
  logic [IMEM_AW-1:0] pc, ifex_pc;
  logic [31:0]        ifex_instr;
  logic               exwb_wen;
  logic [RAW-1:0]     exwb_rd;
  logic [XLEN-1:0]    exwb_result;

  logic [6:0]         opcode, funct7;
  logic [2:0]         funct3;
  logic [RAW-1:0]     rs1, rs2, rd;
  logic signed [11:0] imm12;
  logic signed [12:0] imm_b, boff;
  logic [XLEN-1:0]    imm_i, a, b;
  logic [IMEM_AW-1:0] target;
  logic               wen_ex, taken;
  logic [XLEN-1:0]    res_ex;
  logic               frozen;

  assign opcode = ifex_instr[6:0];
  assign funct3 = ifex_instr[14:12];
  assign funct7 = ifex_instr[31:25];
  assign rd     = ifex_instr[7 +: RAW];
  assign rs1    = ifex_instr[15 +: RAW];
  assign rs2    = ifex_instr[20 +: RAW];
  assign imm12  = ifex_instr[31:20];
  assign imm_i  = XLEN'(imm12);
  assign imm_b  = {ifex_instr[31], ifex_instr[7], ifex_instr[30:25], ifex_instr[11:8], 1'b0};
  assign boff   = imm_b >>> 2;
  assign target = ifex_pc + IMEM_AW'(boff);
  assign frozen = hold || load_en;

  // x0 reads as zero and is never forwarded, so the rs==0 test comes first
  assign a = (rs1 == '0) ? '0 : (exwb_wen && exwb_rd == rs1) ? exwb_result : regs[rs1];
  assign b = (rs2 == '0) ? '0 : (exwb_wen && exwb_rd == rs2) ? exwb_result : regs[rs2];

  always_comb begin
    wen_ex = 1'b0;
    res_ex = '0;
    taken  = 1'b0;
    case (opcode)
      7'b0010011: begin
        wen_ex = 1'b1;
        case (funct3)
          3'b000:  res_ex = a + imm_i;
          3'b010:  res_ex = {{(XLEN-1){1'b0}}, $signed(a) < $signed(imm_i)};
          3'b100:  res_ex = a ^ imm_i;
          3'b110:  res_ex = a | imm_i;
          3'b111:  res_ex = a & imm_i;
          default: wen_ex = 1'b0;
        endcase
      end
      7'b0110011: begin
        wen_ex = 1'b1;
        case ({funct7, funct3})
          {7'h00, 3'b000}: res_ex = a + b;
          {7'h20, 3'b000}: res_ex = a - b;
          {7'h00, 3'b001}: res_ex = a << b[SHW-1:0];
          {7'h00, 3'b010}: res_ex = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
          {7'h00, 3'b100}: res_ex = a ^ b;
          {7'h00, 3'b101}: res_ex = a >> b[SHW-1:0];
          {7'h00, 3'b110}: res_ex = a | b;
          {7'h00, 3'b111}: res_ex = a & b;
          default:         wen_ex = 1'b0;
        endcase
      end
      7'b1100011: begin
        if (funct3 == 3'b000)      taken = (a == b);
        else if (funct3 == 3'b001) taken = (a != b);
      end
      default: ;
    endcase
  end

  // imem has no reset so a program survives a core reset
  always_ff @(posedge clk) begin
    if (rst && load_en) imem[load_addr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc          <= '0;
      ifex_pc     <= '0;
      ifex_instr  <= '0;
      exwb_wen    <= 1'b0;
      exwb_rd     <= '0;
      exwb_result <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (exwb_wen && exwb_rd != '0) regs[exwb_rd] <= exwb_result;
      if (frozen) begin
        exwb_wen    <= 1'b0;
        exwb_rd     <= '0;
        exwb_result <= '0;
      end else begin
        exwb_wen    <= wen_ex;
        exwb_rd     <= rd;
        exwb_result <= res_ex;
        if (taken) begin
          pc         <= target;
          ifex_pc    <= '0;
          ifex_instr <= '0;
        end else begin
          pc         <= pc + 1'b1;
          ifex_pc    <= pc;
          ifex_instr <= imem[pc];
        end
      end
    end
  end

  assign out       = exwb_result;
  assign out_valid = exwb_wen && (exwb_rd != '0);
  assign pc_out    = pc;
endmodule

// File: tb/tb_pipelined_rv_core.sv
// tb/tb_pipelined_rv_core.sv - directed-vector bench for pipelined_rv_core
module tb_pipelined_rv_core;
  logic        clk = 1'b0;
  logic        rst, hold, load_en;
  logic [3:0]  load_addr;
  logic [31:0] load_data;
  logic [15:0] dout;
  logic        out_valid;
  logic [3:0]  pc_out;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] prog [16];

  pipelined_rv_core dut (
    .clk(clk), .rst(rst), .hold(hold), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data),
    .out(dout), .out_valid(out_valid), .pc_out(pc_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] i_op(input int f3, input int rd, input int rs1, input int imm);
    logic [11:0] im;
    im = imm[11:0];
    return {im, rs1[4:0], f3[2:0], rd[4:0], 7'b0010011};
  endfunction

  function automatic logic [31:0] r_op(input int f7, input int f3, input int rd, input int rs1, input int rs2);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] b_op(input int f3, input int rs1, input int rs2, input int off);
    logic [12:0] im;
    im = off[12:0];
    return {im[12], im[10:5], rs2[4:0], rs1[4:0], f3[2:0], im[4:1], im[11], 7'b1100011};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 32'h0;
  endtask

  // reset, load all 16 words, release; returns just after edge 0
  task automatic start();
    rst = 1'b0; hold = 1'b0; load_en = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      load_en = 1'b1; load_addr = 4'(i); load_data = prog[i];
      tick();
    end
    load_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_load();
    logic [15:0] exp [4];
    exp = '{16'd5, 16'hFFFD, 16'd2, 16'hFFF8};
    rst = 1'b0; hold = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    tick(); tick();
    n_cmp++; if (dout !== 16'd0) begin n_bad++; $display("FAIL reset_out got %h want 0000", dout); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (pc_out !== 4'd0) begin n_bad++; $display("FAIL reset_pc got %0d want 0", pc_out); end
    clear_prog();
    prog[0] = i_op(0, 1, 0, 5);
    prog[1] = i_op(0, 2, 0, -3);
    prog[2] = r_op(0, 0, 3, 1, 2);
    prog[3] = r_op(32, 0, 4, 2, 1);
    start();
    n_cmp++; if (pc_out !== 4'd1) begin n_bad++; $display("FAIL load_pc0 got %0d want 1", pc_out); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (dout !== exp[i]) begin n_bad++; $display("FAIL load_out[%0d] got %h want %h", i, dout, exp[i]); end
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL load_valid[%0d] got %b want 1", i, out_valid); end
      n_cmp++; if (pc_out !== 4'(i + 2)) begin n_bad++; $display("FAIL load_pc[%0d] got %0d want %0d", i, pc_out, i + 2); end
    end
  endtask

  task automatic test_forward();
    clear_prog();
    prog[0] = i_op(0, 1, 0, 1);
    for (int i = 1; i < 5; i++) prog[i] = i_op(0, 1, 1, 1);
    start();
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (dout !== 16'(i + 1) || out_valid !== 1'b1) begin
        n_bad++; $display("FAIL fwd[%0d] got %h/%b want %h/1", i, dout, out_valid, 16'(i + 1));
      end
    end
  endtask

  task automatic test_alu();
    logic [15:0] exp [16];
    exp = '{16'hFFF8, 16'h0003, 16'h0018, 16'h1FFF, 16'h0001, 16'h0000, 16'h0000, 16'h00F3,
            16'hFFFD, 16'h07F8, 16'hFFFB, 16'h0000, 16'hFFFD, 16'h0013, 16'h0018, 16'h0001};
    prog[0]  = i_op(0, 1, 0, -8);
    prog[1]  = i_op(0, 2, 0, 3);
    prog[2]  = r_op(0, 1, 3, 2, 2);
    prog[3]  = r_op(0, 5, 4, 1, 2);
    prog[4]  = r_op(0, 2, 5, 1, 2);
    prog[5]  = r_op(0, 2, 6, 2, 1);
    prog[6]  = i_op(2, 7, 1, -9);
    prog[7]  = i_op(4, 8, 2, 'hF0);
    prog[8]  = i_op(6, 9, 1, 5);
    prog[9]  = i_op(7, 10, 1, 'h7FF);
    prog[10] = r_op(0, 4, 11, 1, 2);
    prog[11] = r_op(0, 7, 12, 1, 2);
    prog[12] = r_op(32, 0, 13, 0, 2);
    prog[13] = i_op(0, 15, 0, 'h13);
    prog[14] = r_op(0, 1, 16, 2, 15);
    prog[15] = i_op(2, 17, 2, 4);
    start();
    for (int i = 0; i < 16; i++) begin
      tick();
      n_cmp++; if (dout !== exp[i] || out_valid !== 1'b1) begin
        n_bad++; $display("FAIL alu[%0d] got %h/%b want %h/1", i, dout, out_valid, exp[i]);
      end
    end
  endtask

  task automatic test_x0();
    clear_prog();
    prog[0] = i_op(0, 0, 0, 7);
    prog[1] = r_op(0, 0, 5, 0, 0);
    start();
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL x0_write_valid got %b want 0", out_valid); end
    tick();
    n_cmp++; if (dout !== 16'd0 || out_valid !== 1'b1) begin
      n_bad++; $display("FAIL x0_read got %h/%b want 0000/1", dout, out_valid);
    end
  endtask

  task automatic test_branch(input bit bne);
    logic [15:0] exp_out [7];
    logic        exp_v   [7];
    logic [3:0]  exp_pc  [7];
    clear_prog();
    prog[0] = i_op(0, 1, 0, 1);
    prog[1] = i_op(0, 2, 0, 2);
    prog[2] = b_op(bne ? 1 : 0, 0, 0, 8);
    prog[3] = i_op(0, 3, 0, 33);
    prog[4] = i_op(0, 4, 0, 44);
    prog[5] = i_op(0, 5, 0, 55);
    prog[6] = r_op(0, 0, 6, 3, 0);
    if (bne) begin
      exp_out = '{16'd1, 16'd2, 16'd0, 16'd33, 16'd44, 16'd55, 16'd33};
      exp_v   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      exp_pc  = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    end else begin
      exp_out = '{16'd1, 16'd2, 16'd0, 16'd0, 16'd44, 16'd55, 16'd0};
      exp_v   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      exp_pc  = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    end
    start();
    for (int i = 0; i < 7; i++) begin
      tick();
      n_cmp++; if (dout !== exp_out[i] || out_valid !== exp_v[i] || pc_out !== exp_pc[i]) begin
        n_bad++;
        $display("FAIL branch%s[%0d] got %h/%b/pc%0d want %h/%b/pc%0d", bne ? "_bne" : "_beq", i,
                 dout, out_valid, pc_out, exp_out[i], exp_v[i], exp_pc[i]);
      end
    end
  endtask

  task automatic test_hold();
    clear_prog();
    prog[0] = i_op(0, 1, 0, 10);
    for (int i = 1; i < 6; i++) prog[i] = i_op(0, 1, 1, 1);
    start();
    tick();
    n_cmp++; if (dout !== 16'd10) begin n_bad++; $display("FAIL hold_pre got %h want 000a", dout); end
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0 || pc_out !== 4'd2) begin
        n_bad++; $display("FAIL hold[%0d] got %b/pc%0d want 0/pc2", i, out_valid, pc_out);
      end
    end
    hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (dout !== 16'(11 + i) || out_valid !== 1'b1 || pc_out !== 4'(3 + i)) begin
        n_bad++; $display("FAIL hold_release[%0d] got %h/%b/pc%0d want %h/1/pc%0d",
                          i, dout, out_valid, pc_out, 16'(11 + i), 3 + i);
      end
    end
  endtask

  task automatic test_wrap_reset();
    for (int i = 0; i < 16; i++) prog[i] = i_op(0, i + 1, 0, i + 1);
    start();
    for (int j = 0; j < 17; j++) begin
      tick();
      n_cmp++; if (dout !== 16'((j % 16) + 1) || pc_out !== 4'((j + 2) % 16)) begin
        n_bad++; $display("FAIL wrap[%0d] got %h/pc%0d want %h/pc%0d",
                          j, dout, pc_out, 16'((j % 16) + 1), (j + 2) % 16);
      end
    end
    rst = 1'b0;
    tick();
    n_cmp++; if (dout !== 16'd0 || out_valid !== 1'b0 || pc_out !== 4'd0) begin
      n_bad++; $display("FAIL midreset got %h/%b/pc%0d want 0000/0/pc0", dout, out_valid, pc_out);
    end
    rst = 1'b1;
    load_en = 1'b1; load_addr = 4'd1; load_data = r_op(0, 0, 17, 16, 15);
    tick();
    load_en = 1'b0;
    tick();
    tick();
    n_cmp++; if (dout !== 16'd1 || out_valid !== 1'b1) begin
      n_bad++; $display("FAIL imem_intact got %h/%b want 0001/1", dout, out_valid);
    end
    tick();
    n_cmp++; if (dout !== 16'd0 || out_valid !== 1'b1) begin
      n_bad++; $display("FAIL regs_cleared got %h/%b want 0000/1", dout, out_valid);
    end
  endtask

  initial begin
    test_reset_load();
    test_forward();
    test_alu();
    test_x0();
    test_branch(1'b0);
    test_branch(1'b1);
    test_hold();
    test_wrap_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pipelined_rv_core.md
# pipelined_rv_core

Parametrised successor to the current three-stage pipelined RISC-V datapath. It generalises data width, register count and instruction-memory depth. It adds behaviour the current datapath lacks:
- x0 hard-wired to zero
- SUB/SLT/shift decode
- BEQ/BNE with pipeline flush
- a hold input
- a program-load port for the instruction memory

It is the top-level compute block; `out`/`out_valid` export the writeback bus.

## Interface
Parameters:
- `XLEN`, default 16: datapath width; legal range 12..32.
- `NREGS`, default 32: register count; legal values 8, 16, 32. `RAW = clog2(NREGS)`.
- `IMEM_DEPTH`, default 16: instruction words; power of two. `IMEM_AW = clog2(IMEM_DEPTH)`.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous, active-low (0 = reset).
- `hold`, in, 1: freeze the pipeline front end.
- `load_en`, in, 1: write `load_data` into the instruction memory at `load_addr`; implies hold.
- `load_addr`, in, `IMEM_AW`: instruction-memory write address (word index).
- `load_data`, in, 32: instruction word to write.
- `out`, out, `XLEN`: writeback-stage result.
- `out_valid`, out, 1: `out` is a register write this cycle.
- `pc_out`, out, `IMEM_AW`: current fetch PC (word index).

## Operation
Stages:
- **IF:** combinational read of `imem[pc]` into the IF/EX register, together with `pc`.
- **EX:** decode, register read, forwarding, ALU, branch resolve. Results go into the EX/WB register (`wen`, `rd`, `result`).
- **WB:** writes the register file at the edge when `wen=1` and `rd != 0`.

Decoded instructions (anything else executes as NOP, `wen=0`):
- Opcode 0010011: ADDI, SLTI, XORI, ORI, ANDI.
- Opcode 0110011: ADD, SUB (funct7 = 0100000), SLL, SLT, XOR, SRL, OR, AND.
- Opcode 1100011: BEQ, BNE.

Field rules:
- Register indices use the low `RAW` bits of rs1/rs2/rd; upper bits are ignored.
- Immediates are sign-extended from bit 31 to `XLEN`.
- Arithmetic wraps modulo 2^`XLEN`. SLT/SLTI are signed and produce 1 or 0.
- Shift amount is the low `clog2(XLEN)` bits of operand 2.

Register x0:
- Reads of x0 return 0.
- x0 is never written.
- x0 is never a forwarding source.

Forwarding:
- Applies when EX rs1 or rs2 equals the WB `rd`, WB `wen=1`, and `rd != 0`.
- In that case EX uses the WB `result` instead of the register-file value.

Branches:
- A branch is taken when BEQ sees operands equal, or BNE sees operands not equal.
- Target = `pc_ex + (imm_b >>> 2)`, truncated to `IMEM_AW` bits; byte-offset bits [1:0] are ignored.
- When taken: `pc` loads the target, the IF/EX register loads a bubble (1-cycle penalty), and the branch itself writes nothing.

PC behaviour:
- Sequential PC increments by 1 and wraps from `IMEM_DEPTH-1` to 0.

Hold (`hold=1` or `load_en=1`):
- `pc` and IF/EX keep their values.
- EX/WB loads a bubble, so the held instruction executes exactly once after release.

Load:
- `imem[load_addr] <= load_data` at the edge.
- An instruction already latched in IF/EX is not refetched after a load.

## Timing
Reset (`rst=0` at an edge), which overrides `hold`, `load_en` and the imem write:
- `pc=0`; IF/EX = bubble.
- EX/WB: `wen=0`, `rd=0`, `result=0`.
- All registers = 0.
- `out=0`, `out_valid=0`, `pc_out=0`.
- The imem contents are preserved.

Cycle numbering: edge 0 is the first edge with `rst=1` and no hold.
- Edge k latches instruction k into IF/EX.
- Edge k+1 latches its result into EX/WB; `out`/`out_valid` are valid from then.
- Edge k+2 commits it to the register file.

Throughput: one instruction per cycle, with no stalls for dependent ALU instructions.

Branch at edge k+1:
- Resolves in the cycle after edge k.
- The fetch after edge k+1 reads the target.
- One bubble is seen at WB.

Simultaneous WB write and EX read of the same register: the forwarded value wins.

`out_valid` is 1 only for non-x0 register writes. `out` still shows the bubble's `result` (0) when invalid.

`pc_out` is registered and equals `pc`.

## Test plan
- **Reset and load.**
  - Stimulus: `rst=0` for 2 cycles; load imem[0..3] = ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SUB x4,x2,x1; then release.
  - Required: `out` = 5, 0xFFFD, 2, 0xFFF8 on consecutive cycles (XLEN=16); `out_valid=1` each cycle.
- **Back-to-back forwarding.**
  - Stimulus: ADDI x1,x0,1 followed by four ADDI x1,x1,1.
  - Required: `out` = 1, 2, 3, 4, 5 with no gaps.
- **x0 handling.**
  - Stimulus: ADDI x0,x0,7; ADD x5,x0,x0.
  - Required: first has `out_valid=0`; second gives `out=0`.
- **Branches.**
  - Stimulus: BEQ x0,x0,+8 at pc 2.
  - Required: `pc_out` goes 3 then 4; one `out_valid=0` bubble; instruction at pc 3 never writes.
  - Stimulus: BNE x0,x0 at pc 2.
  - Required: falls through with no bubble.
- **Hold mid-stream.**
  - Stimulus: `hold=1` for 3 cycles during a run.
  - Required: `pc_out` frozen, `out_valid=0` for 3 cycles; the next result appears exactly once after release.
- **Wrap and mid-run reset.**
  - Stimulus: with IMEM_DEPTH=16, run through pc 15.
  - Required: pc wraps to 0.
  - Stimulus: assert `rst=0` for 1 cycle mid-run.
  - Required: `pc_out=0`, `out=0`, registers cleared, imem intact.
